// File: rtl/alu_issue_ctrl_if.sv
// Bundle of every handshake/bus signal between alu_issue_ctrl and its
// neighbours: the command source, the external combinational ALU and the
// result consumer. clk/rst are carried as plain ports on the modules.
// Optional macro: ALU_STICKY_OVF_EN adds ovf_clr / ovf_sticky.
//
// Handshake semantics (both cmd_* and res_*): a transfer happens on a rising
// edge where valid and ready are both 1. The producer holds valid and its
// payload stable until that edge; ready may be asserted independently of valid.
interface alu_issue_ctrl_if #(
  parameter int W  = 8,
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic          cmd_imm_sel;
  logic [W-1:0]  cmd_imm;

  logic [W-1:0]  alu_x;
  logic [W-1:0]  alu_y;
  logic [2:0]    alu_judge;
  logic [W-1:0]  alu_result;
  logic          alu_overflow;

  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_ovf;

`ifdef ALU_STICKY_OVF_EN
  logic          ovf_clr;
  logic          ovf_sticky;
`endif

  // Issue stage side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm,
    input  alu_result, alu_overflow, res_ready,
`ifdef ALU_STICKY_OVF_EN
    input  ovf_clr,
    output ovf_sticky,
`endif
    output cmd_ready, alu_x, alu_y, alu_judge, res_valid, res_data, res_ovf
  );

  // Environment side: command source, ALU and result consumer
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm,
    output alu_result, alu_overflow, res_ready,
`ifdef ALU_STICKY_OVF_EN
    output ovf_clr,
    input  ovf_sticky,
`endif
    input  cmd_ready, alu_x, alu_y, alu_judge, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue / write-back stage in front of an 8-bit combinational ALU.
// Accepts a command, reads operands from a small register file into the ALU
// input registers, lets the ALU settle for one cycle, then captures the
// result, writes it back and holds it on the result handshake.
// Optional macro: ALU_STICKY_OVF_EN (sticky overflow flag with clear input).
module alu_issue_ctrl #(
  parameter int W    = 8,
  parameter int NREG = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic [1:0]       state_o
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic          exec_done;
  logic          res_take;
  logic          ovf_now;

  logic [W-1:0]  rf_q [NREG];
  logic [AW-1:0] rd_q;
  logic [W-1:0]  alu_x_q;
  logic [W-1:0]  alu_y_q;
  logic [2:0]    judge_q;
  logic          res_valid_q;
  logic [W-1:0]  res_data_q;
  logic          res_ovf_q;

  // Next-state decode and the per-state strobes that drive the datapath
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    exec_done = 1'b0;
    res_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Overflow is only meaningful for add (000) and sub (001)
  assign ovf_now = (judge_q[2:1] == 2'b00) & bus.alu_overflow;

  // ALU input registers and destination latch; held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x_q <= '0;
      alu_y_q <= '0;
      judge_q <= 3'b000;
      rd_q    <= '0;
    end else if (accept) begin
      alu_x_q <= rf_q[bus.cmd_rs1];
      alu_y_q <= bus.cmd_imm_sel ? bus.cmd_imm : rf_q[bus.cmd_rs2];
      judge_q <= bus.cmd_op;
      rd_q    <= bus.cmd_rd;
    end
  end

  // Register file: write-back at the close of EXEC, before the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (exec_done) begin
      rf_q[rd_q] <= bus.alu_result;
    end
  end

  // Result capture and result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else if (exec_done) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.alu_result;
      res_ovf_q   <= ovf_now;
    end else if (res_take) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: set by a captured overflow, cleared by ovf_clr; set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sticky_q <= 1'b0;
    else if (exec_done && ovf_now) sticky_q <= 1'b1;
    else if (bus.ovf_clr)          sticky_q <= 1'b0;
  end

  assign bus.ovf_sticky = sticky_q;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.alu_judge = judge_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign state_o       = state_q;
endmodule
